// File: rtl/neck_pkg.sv
// neck_pkg: shared state encoding, warmup length, count saturation and default thresholds for neck_detect.
package neck_pkg;
  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_SEEK   = 2'd1;
  localparam logic [1:0] ST_FALL   = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;
  localparam int WARM_LEN = 3;
  localparam int CNT_SAT = 255;
  localparam int FALL_MIN_DEF = 3;
  localparam int HOLDOFF_DEF = 16;
  localparam int IDX_W_DEF = 16;
  localparam logic signed [12:0] CURV_TH_DEF = 13'sd4;
  localparam logic signed [12:0] JERK_TH_DEF = 13'sd200;
endpackage

// File: rtl/neck_sat_counter.sv
// neck_sat_counter: W-bit incrementer that either saturates at all-ones (SAT=1) or wraps (SAT=0).
module neck_sat_counter #(
  parameter int W = 8,
  parameter bit SAT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (inc && !(SAT && &q)) q <= q + W'(1);
endmodule

// File: rtl/neck_detect.sv
// neck_detect: finds local minima (sustained descent, then non-negative slope with enough curvature).
// Optional NECK_JERK_CHECK_EN adds third_dif_data and a |jerk| <= JERK_TH qualifier.
module neck_detect
  import neck_pkg::*;
#(
  parameter int FALL_MIN = FALL_MIN_DEF,
  parameter logic signed [12:0] CURV_TH = CURV_TH_DEF,
  parameter int HOLDOFF = HOLDOFF_DEF,
`ifdef NECK_JERK_CHECK_EN
  parameter logic signed [12:0] JERK_TH = JERK_TH_DEF,
`endif
  parameter int IDX_W = IDX_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    dif_finish,
  input  logic signed [12:0]      first_dif_data,
  input  logic signed [12:0]      second_dif_data,
`ifdef NECK_JERK_CHECK_EN
  input  logic signed [12:0]      third_dif_data,
`endif
  output logic                    neck_valid,
  output logic [IDX_W-1:0]        neck_index,
  output logic signed [12:0]      neck_curv,
  output logic [7:0]              neck_count
);
  logic [1:0] state, state_n, warm_cnt, warm_n;
  logic [3:0] fall_cnt, fall_n, fall_inc;
  logic [7:0] hold_cnt, hold_n;
  logic [IDX_W-1:0] idx;
  logic neg, curv_ok, jerk_ok, hit;
  assign neg = first_dif_data < 13'sd0;
  assign curv_ok = second_dif_data >= CURV_TH;
`ifdef NECK_JERK_CHECK_EN
  // 14-bit magnitude so that -4096 stays representable
  localparam logic signed [13:0] JERK_TH14 = JERK_TH;
  logic signed [13:0] third_ext, third_abs;
  assign third_ext = third_dif_data;
  assign third_abs = third_ext < 14'sd0 ? -third_ext : third_ext;
  assign jerk_ok = third_abs <= JERK_TH14;
`else
  assign jerk_ok = 1'b1;
`endif
  assign hit = dif_finish && state == ST_FALL && !neg && curv_ok && jerk_ok;
  assign fall_inc = fall_cnt + 4'd1;
  always_comb begin
    state_n = state;
    fall_n = fall_cnt;
    hold_n = hold_cnt;
    warm_n = warm_cnt;
    if (dif_finish)
      case (state)
        ST_WARMUP: begin
          warm_n = warm_cnt + 2'd1;
          fall_n = '0;
          state_n = warm_cnt == 2'(WARM_LEN - 1) ? ST_SEEK : ST_WARMUP;
        end
        ST_SEEK: begin
          fall_n = neg ? fall_inc : '0;
          state_n = neg && fall_inc == 4'(FALL_MIN) ? ST_FALL : ST_SEEK;
        end
        ST_FALL: begin
          fall_n = '0;
          hold_n = hit ? 8'(HOLDOFF) : hold_cnt;
          state_n = neg ? ST_FALL : (hit && HOLDOFF != 0) ? ST_HOLD : ST_SEEK;
        end
        default: begin
          hold_n = hold_cnt - 8'd1;
          state_n = hold_cnt == 8'd1 ? ST_SEEK : ST_HOLD;
        end
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_WARMUP;
      warm_cnt <= '0;
      fall_cnt <= '0;
      hold_cnt <= '0;
      neck_valid <= 1'b0;
      neck_index <= '0;
      neck_curv <= '0;
    end else begin
      state <= state_n;
      warm_cnt <= warm_n;
      fall_cnt <= fall_n;
      hold_cnt <= hold_n;
      neck_valid <= hit;
      if (hit) begin
        neck_index <= idx;
        neck_curv <= second_dif_data;
      end
    end
  neck_sat_counter #(.W(IDX_W), .SAT(1'b0)) u_idx (
    .clk(clk), .rst_n(rst_n), .inc(dif_finish), .q(idx)
  );
  neck_sat_counter #(.W($clog2(CNT_SAT + 1)), .SAT(1'b1)) u_cnt (
    .clk(clk), .rst_n(rst_n), .inc(hit), .q(neck_count)
  );
endmodule

// File: doc/neck_detect.md
# neck_detect

Downstream consumer of the three-stage differentiator in the neck-check signal chain. Takes the registered first/second-difference samples qualified by `dif_finish`. Locates "neck" points: local minima of the input waveform, where the slope crosses from a sustained descent to non-negative with sufficient positive curvature. For each neck it emits a one-cycle report carrying the sample index and curvature, and keeps a saturating neck count.

## Interface
- `FALL_MIN`, 3: consecutive negative first-difference samples required to arm detection (1..15).
- `CURV_TH`, 13'sd4: minimum second difference at the crossing sample.
- `HOLDOFF`, 16: valid samples ignored after a reported neck (0..255).
- `IDX_W`, 16: width of the sample index.
- `JERK_TH`, 13'sd200: maximum |third difference| at the crossing; used only with `NECK_JERK_CHECK_EN`.
- `clk` input 1: system clock; one clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `dif_finish` input 1: sample-valid strobe; the difference inputs are sampled only when this is 1.
- `first_dif_data` input 13 signed: first difference.
- `second_dif_data` input 13 signed: second difference.
- `third_dif_data` input 13 signed: third difference; present only with `NECK_JERK_CHECK_EN`.
- `neck_valid` output 1: one-cycle report pulse.
- `neck_index` output IDX_W: index of the crossing sample.
- `neck_curv` output 13 signed: `second_dif_data` at the crossing sample.
- `neck_count` output 8: number of necks reported, saturating at 255.

## Operation
- Sample index `idx`: counts every valid sample from reset. The first valid sample has index 0. Wraps from 2^IDX_W−1 to 0.
- States: WARMUP, SEEK, FALL, HOLD. Reset state is WARMUP. State transitions occur only on valid samples.
- WARMUP: discards the first 3 valid samples, because the differentiator history is zero-filled. After the 3rd sample, go to SEEK with `fall_cnt`=0.
- SEEK:
  - `first_dif_data` < 0: increment `fall_cnt`. If the new value equals FALL_MIN, go to FALL.
  - `first_dif_data` >= 0: clear `fall_cnt`.
- FALL:
  - `first_dif_data` < 0: stay in FALL.
  - `first_dif_data` >= 0 and `second_dif_data` >= CURV_TH: this is a neck. Report it, load `hold_cnt`=HOLDOFF, and go to HOLD, or to SEEK if HOLDOFF=0.
  - `first_dif_data` >= 0 and the curvature check fails: go to SEEK with `fall_cnt`=0.
- HOLD:
  - Each valid sample decrements `hold_cnt`.
  - The sample that brings `hold_cnt` to 0 returns the block to SEEK with `fall_cnt`=0. HOLD therefore consumes exactly HOLDOFF samples, and their contents are ignored.
- Comparisons are signed 13-bit. Zero slope counts as non-negative.
- Report: latch `neck_index`=idx of the crossing sample and `neck_curv`. Increment `neck_count` unless it is already 255.
- Between reports, `neck_index` and `neck_curv` hold their last values.

## Timing
- Reset values: `neck_valid`=0, `neck_index`=0, `neck_curv`=0, `neck_count`=0. Internally, `idx`=0, `fall_cnt`=0, `hold_cnt`=0, state=WARMUP.
- Latency: `neck_valid` asserts on the clock edge after the crossing sample's `dif_finish` cycle, and lasts exactly 1 cycle. `neck_index`, `neck_curv` and `neck_count` update on that same edge.
- `dif_finish` may be high on consecutive cycles, so back-to-back samples are accepted. Cycles with `dif_finish`=0 change nothing except deasserting `neck_valid`.
- Asserting `rst_n` mid-operation, in any state, clears everything immediately. The warmup is then repeated.

## Configuration
- `NECK_JERK_CHECK_EN` defined:
  - The `third_dif_data` port exists.
  - A FALL crossing is reported only if the curvature check passes and |`third_dif_data`| <= JERK_TH.
  - A failed jerk check is handled like a failed curvature check: go to SEEK.
  - Absolute value is computed at 14 bits, so −4096 does not overflow.
- `NECK_JERK_CHECK_EN` undefined: the port and the check are both absent.

## Structure
- Package `neck_pkg`: state encoding (WARMUP/SEEK/FALL/HOLD), the WARMUP length constant 3, the count saturation value 255, and the default thresholds.
- Sub-module `neck_sat_counter`: parameterized-width increment with saturate or wrap mode. It is instantiated for `neck_count` (saturate) and for `idx` (wrap).
- The FSM and the report registers sit in the top level.

## Test plan
- Warmup and basic detection, defaults:
  - Stimulus: 3 warmup samples, then `first_dif` = −5, −5, −5, then +2 with `second_dif`=7.
  - Response: a single `neck_valid` pulse one cycle after the +2 sample, with `neck_index`=6, `neck_curv`=7, `neck_count`=1.
- Warmup exclusion: negative slopes at indices 0–2 followed by `first_dif`=+1, `second_dif`=9 at index 3 -> no report, because FALL was never reached.
- Curvature reject: the same descent, then the crossing with `second_dif`=3 -> no pulse. A later valid descent (3 negatives) plus crossing with `second_dif`=4 then reports.
- Holdoff: after a neck at index 6, a full neck pattern inside samples 7–22 -> ignored. The same pattern starting at index 23 -> reported, `neck_count`=2.
- Saturation and reset: 260 qualifying necks with HOLDOFF=0 -> `neck_count` stays 255. Dropping `rst_n` while in FALL -> all outputs read 0 immediately, and the next neck requires a new warmup.
- With `NECK_JERK_CHECK_EN`: a valid crossing with `third_dif`=−201 -> rejected. The same crossing with `third_dif`=200 -> reported.
